// File: rtl/popcount22_pkg.sv
// popcount22_pkg: shared widths, FSM state encoding and mask type for the popcount scheduler
package popcount22_pkg;
  localparam int N_IN = 22;
  localparam int PC_W = 5;
  typedef logic [N_IN-1:0] mask_t;
  typedef enum logic [2:0] {S_IDLE, S_POS, S_POS_W, S_NEG, S_NEG_W, S_DONE} state_t;
endpackage

// File: rtl/popcount22_core.sv
// popcount22_core: exact combinational 22-input popcount as a balanced adder tree
module popcount22_core
  import popcount22_pkg::*;
(
  input  mask_t           a,
  output logic [PC_W-1:0] pc
);
  logic [1:0] s1 [11];
  logic [2:0] s2 [6];
  logic [3:0] s3 [3];
  for (genvar i = 0; i < 11; i++) begin : g_l1
    assign s1[i] = 2'(a[2*i]) + 2'(a[2*i+1]);
  end
  for (genvar i = 0; i < 5; i++) begin : g_l2
    assign s2[i] = 3'(s1[2*i]) + 3'(s1[2*i+1]);
  end
  assign s2[5] = 3'(s1[10]);
  for (genvar i = 0; i < 3; i++) begin : g_l3
    assign s3[i] = 4'(s2[2*i]) + 4'(s2[2*i+1]);
  end
  assign pc = 5'(s3[0]) + 5'(s3[1]) + 5'(s3[2]);
endmodule

// File: rtl/popcount22_neuron_sched.sv
// popcount22_neuron_sched: shares one popcount22 unit across NUM_NEURONS ternary neurons.
// Define POPCNT_PIPE_REG_EN to register the popcount output (extra wait state per pass).
module popcount22_neuron_sched
  import popcount22_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int THR_W       = 6,
  localparam int IDX_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_addr,
  input  logic [N_IN-1:0]         cfg_wpos,
  input  logic [N_IN-1:0]         cfg_wneg,
  input  logic [THR_W-1:0]        cfg_thr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN-1:0]         in_x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_NEURONS-1:0]  out_act
);
`ifdef POPCNT_PIPE_REG_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif
  state_t                   state, state_d;
  mask_t                    wp [NUM_NEURONS];
  mask_t                    wn [NUM_NEURONS];
  logic signed [THR_W-1:0]  thr [NUM_NEURONS];
  mask_t                    x_q, operand;
  logic [IDX_W-1:0]         idx;
  logic [PC_W-1:0]          pc, pc_use, pos_q;
  logic signed [THR_W-1:0]  diff;
  logic                     last, act, accept, pos_st, eval_st;

  popcount22_core u_pc (.a(operand), .pc(pc));

`ifdef POPCNT_PIPE_REG_EN
  logic [PC_W-1:0] pc_q;
  // Pipeline register on the popcount result to cut the adder tree from the comparator path
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= '0;
    else pc_q <= pc;
  assign pc_use = pc_q;
`else
  assign pc_use = pc;
`endif

  assign last    = idx == IDX_W'(NUM_NEURONS - 1);
  assign accept  = in_valid && in_ready;
  assign pos_st  = state == (PIPE ? S_POS_W : S_POS);
  assign eval_st = state == (PIPE ? S_NEG_W : S_NEG);
  assign diff    = THR_W'(pos_q) - THR_W'(pc_use);
  assign act     = diff >= thr[idx];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_d;

  // Next-state: two popcount passes per neuron, optional wait cycle after each
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  state_d = accept ? S_POS : S_IDLE;
      S_POS:   state_d = PIPE ? S_POS_W : S_NEG;
      S_POS_W: state_d = S_NEG;
      S_NEG:   state_d = PIPE ? S_NEG_W : (last ? S_DONE : S_POS);
      S_NEG_W: state_d = last ? S_DONE : S_POS;
      S_DONE:  state_d = out_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; popcount operand is held at zero outside the issuing states to avoid toggling
  always_comb begin
    in_ready  = rst_n && state == S_IDLE && !cfg_we;
    out_valid = state == S_DONE;
    operand   = state == S_POS ? x_q & wp[idx] & ~wn[idx] :
                state == S_NEG ? x_q & wn[idx] & ~wp[idx] : '0;
  end

  // Weight store, input latch, positive-count latch and per-neuron activation update
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        wp[n]  <= '0;
        wn[n]  <= '0;
        thr[n] <= '0;
      end
      x_q     <= '0;
      idx     <= '0;
      pos_q   <= '0;
      out_act <= '0;
    end else begin
      if (state == S_IDLE && cfg_we && int'(cfg_addr) < NUM_NEURONS) begin
        wp[cfg_addr]  <= cfg_wpos;
        wn[cfg_addr]  <= cfg_wneg;
        thr[cfg_addr] <= cfg_thr;
      end
      if (accept) begin
        x_q <= in_x;
        idx <= '0;
      end
      if (pos_st) pos_q <= pc_use;
      if (eval_st) begin
        out_act[idx] <= act;
        idx          <= last ? idx : idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_popcount22_neuron_sched.sv
// tb_popcount22_neuron_sched: randomized and directed checks against a behavioural neuron model
module tb_popcount22_neuron_sched;
  localparam int N  = 4;
  localparam int TW = 6;
`ifdef POPCNT_PIPE_REG_EN
  localparam int LAT = 4 * N;
`else
  localparam int LAT = 2 * N;
`endif
  logic          clk = 0, rst_n = 0, cfg_we = 0, in_valid = 0, out_ready = 0;
  logic [1:0]    cfg_addr = 0;
  logic [21:0]   cfg_wpos = 0, cfg_wneg = 0, in_x = 0;
  logic [TW-1:0] cfg_thr = 0;
  logic          in_ready, out_valid;
  logic [N-1:0]  out_act;
  int            nvec = 0, nerr = 0;
  logic [21:0]   mwp [N];
  logic [21:0]   mwn [N];
  int            mthr [N];

  always #5 clk = ~clk;

  popcount22_neuron_sched #(.NUM_NEURONS(N), .THR_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wpos(cfg_wpos),
    .cfg_wneg(cfg_wneg), .cfg_thr(cfg_thr), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act)
  );

  function automatic logic [N-1:0] model(input logic [21:0] x);
    logic [N-1:0] r;
    for (int n = 0; n < N; n++) begin
      int p, q;
      p = $countones(x & mwp[n] & ~mwn[n]);
      q = $countones(x & mwn[n] & ~mwp[n]);
      r[n] = (p - q) >= mthr[n];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int n = 0; n < N; n++) begin
      mwp[n] = 0; mwn[n] = 0; mthr[n] = 0;
    end
  endtask

  task automatic cfg(input int a, input logic [21:0] p, input logic [21:0] q, input int t);
    cfg_we = 1; cfg_addr = 2'(a); cfg_wpos = p; cfg_wneg = q; cfg_thr = TW'(t);
    in_valid = 1;
    #1;
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++; $display("FAIL cfg_blocks_ready: in_ready=%b want 0", in_ready);
    end
    @(posedge clk); #1;
    cfg_we = 0; in_valid = 0;
    if (a < N) begin
      mwp[a] = p; mwn[a] = q; mthr[a] = t;
    end
  endtask

  task automatic run(input logic [21:0] x, output logic [N-1:0] act);
    logic [N-1:0] exp;
    int c;
    exp = model(x);
    c = 0;
    while (in_ready !== 1'b1 && c < 50) begin
      @(posedge clk); #1; c++;
    end
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL ready_timeout: in_ready=%b want 1", in_ready);
    end
    in_valid = 1; in_x = x;
    @(posedge clk); #1;
    in_valid = 0; in_x = 22'($urandom);
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++; $display("FAIL busy_ready: in_ready=%b want 0", in_ready);
    end
    c = 0;
    while (out_valid !== 1'b1 && c < 100) begin
      @(posedge clk); #1; c++;
    end
    nvec++;
    if (c !== LAT) begin
      nerr++; $display("FAIL latency: got %0d cycles want %0d", c, LAT);
    end
    nvec++;
    if (out_act !== exp) begin
      nerr++; $display("FAIL act x=%h: got %b want %b", x, out_act, exp);
    end
    act = out_act;
  endtask

  task automatic xfer();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++; $display("FAIL xfer_drop: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset();
    model_clear();
    #2;
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_act !== '0) begin
      nerr++; $display("FAIL reset: valid=%b ready=%b act=%b want 0 0 0", out_valid, in_ready, out_act);
    end
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL idle_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_zero_weights();
    logic [N-1:0] a;
    run(22'h3FFFFF, a);
    nvec++;
    if (a !== 4'b1111) begin
      nerr++; $display("FAIL zero_weights: got %b want 1111", a);
    end
    xfer();
  endtask

  task automatic test_directed();
    logic [N-1:0] a;
    cfg(0, 22'h0000FF, 22'h00FF00, 1);
    run(22'h0000F0, a);
    nvec++;
    if (a[0] !== 1'b1) begin
      nerr++; $display("FAIL n0_pos: act0=%b want 1", a[0]);
    end
    xfer();
    run(22'h00F000, a);
    nvec++;
    if (a[0] !== 1'b0) begin
      nerr++; $display("FAIL n0_neg: act0=%b want 0", a[0]);
    end
    xfer();
    cfg(1, 22'h3FFFFF, 22'h3FFFFF, 0);
    cfg(2, 22'h3FFFFF, 22'h000000, 22);
    run(22'h3FFFFF, a);
    nvec++;
    if (a[2:1] !== 2'b11) begin
      nerr++; $display("FAIL n1n2_max: act[2:1]=%b want 11", a[2:1]);
    end
    xfer();
    cfg(2, 22'h3FFFFF, 22'h000000, -22);
    run(22'h000000, a);
    nvec++;
    if (a[2] !== 1'b1) begin
      nerr++; $display("FAIL n2_minthr: act2=%b want 1", a[2]);
    end
    xfer();
  endtask

  task automatic test_hold();
    logic [N-1:0] a;
    run(22'h0F0F0F, a);
    for (int i = 0; i < 5; i++) begin
      cfg_we = 1; cfg_addr = 2'(i % N); cfg_wpos = 22'h3FFFFF; cfg_wneg = 22'h000000; cfg_thr = TW'(23);
      @(posedge clk); #1;
      nvec++;
      if (out_valid !== 1'b1 || out_act !== a || in_ready !== 1'b0) begin
        nerr++; $display("FAIL hold: valid=%b act=%b ready=%b want 1 %b 0", out_valid, out_act, in_ready, a);
      end
    end
    cfg_we = 0;
    xfer();
    run(22'h0F0F0F, a);
    xfer();
  endtask

  task automatic test_random();
    logic [N-1:0] a;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(1) == 1)
        cfg(int'($urandom_range(N - 1)), 22'($urandom), 22'($urandom), int'($urandom_range(44)) - 22);
      run(22'($urandom), a);
      xfer();
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] a;
    int c;
    c = 0;
    while (in_ready !== 1'b1 && c < 50) begin
      @(posedge clk); #1; c++;
    end
    in_valid = 1; in_x = 22'h155555;
    @(posedge clk); #1;
    in_valid = 0;
    rst_n = 0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || out_act !== '0 || in_ready !== 1'b0) begin
      nerr++; $display("FAIL reset_mid: valid=%b act=%b ready=%b want 0 0 0", out_valid, out_act, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1;
    model_clear();
    run(22'h3FFFFF, a);
    nvec++;
    if (a !== 4'b1111) begin
      nerr++; $display("FAIL post_reset_weights: got %b want 1111", a);
    end
    xfer();
  endtask

  initial begin
    test_reset();
    test_zero_weights();
    test_directed();
    test_hold();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
